// File: rtl/ras.sv
// Return address stack: circular store of predicted call return targets (PC[31:1]).
// Latency: push/pop/restore update state on one CLK edge; outputs are read from registered state only.
// Backpressure: none; every input is sampled each cycle and callers gate the valids.
//
// Ports:
//   CLK, RST                    core clock, asynchronous active-high reset
//   link_valid, link_target     predicted call: push link_target
//   ret_valid                   predicted return: pop
//   restore_valid/index/count   restore top pointer and depth from a frontend checkpoint
//   ret_target                  entry at the current top (stack[index]), valid only when !ras_empty
//   ras_index, ras_count        current top pointer and valid depth, for checkpointing
//   ras_empty                   depth is zero
module ras #(
    parameter int RAS_ENTRIES      = 8,   // power of two
    parameter int RAS_INDEX_WIDTH  = 3,   // $clog2(RAS_ENTRIES)
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        link_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] link_target,
    input  logic                        ret_valid,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
    input  logic [RAS_INDEX_WIDTH:0]    restore_count,
    output logic [RAS_TARGET_WIDTH-1:0] ret_target,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count,
    output logic                        ras_empty
);

    localparam logic [RAS_INDEX_WIDTH:0]   CNT_FULL = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);
    localparam logic [RAS_INDEX_WIDTH:0]   CNT_ONE  = (RAS_INDEX_WIDTH+1)'(1);
    localparam logic [RAS_INDEX_WIDTH:0]   CNT_ZERO = '0;
    localparam logic [RAS_INDEX_WIDTH-1:0] IDX_ONE  = RAS_INDEX_WIDTH'(1);

    logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_ENTRIES];
    logic [RAS_TARGET_WIDTH-1:0] stack_d [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  index_q, index_d;
    logic [RAS_INDEX_WIDTH:0]    count_q, count_d;

    // Single write port: at most one entry is written per cycle.
    logic                        wr_en;
    logic [RAS_INDEX_WIDTH-1:0]  wr_idx;

    logic push_only;
    logic pop_only;
    logic push_pop;

    assign push_only = link_valid & ~ret_valid;
    assign pop_only  = ret_valid & ~link_valid;
    assign push_pop  = link_valid & ret_valid;

    always_comb begin
        index_d = index_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = index_q;

        if (restore_valid) begin
            // Checkpoint restore wins over any push/pop in the same cycle.
            // Contents are left alone; only pointer and depth roll back.
            index_d = restore_index;
            count_d = (restore_count > CNT_FULL) ? CNT_FULL : restore_count;
        end else if (push_only) begin
            // Index wraps naturally; at full depth this overwrites the oldest entry.
            wr_en   = 1'b1;
            wr_idx  = index_q + IDX_ONE;
            index_d = index_q + IDX_ONE;
            count_d = (count_q == CNT_FULL) ? CNT_FULL : count_q + CNT_ONE;
        end else if (pop_only) begin
            // Popping an empty stack is a no-op so the pointer stays consistent.
            if (count_q != CNT_ZERO) begin
                index_d = index_q - IDX_ONE;
                count_d = count_q - CNT_ONE;
            end
        end else if (push_pop) begin
            // Return then call in one fetch: replace the top in place.
            wr_en   = 1'b1;
            wr_idx  = index_q;
            count_d = (count_q == CNT_ZERO) ? CNT_ONE : count_q;
        end

        for (int i = 0; i < RAS_ENTRIES; i++) begin
            stack_d[i] = stack_q[i];
        end
        if (wr_en) begin
            stack_d[wr_idx] = link_target;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            index_q <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            index_q <= index_d;
            count_q <= count_d;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    // Outputs come only from registered state; no input-to-output path.
    assign ret_target = stack_q[index_q];
    assign ras_index  = index_q;
    assign ras_count  = count_q;
    assign ras_empty  = (count_q == CNT_ZERO);

endmodule

// File: tb/tb_ras.sv
// Testbench for ras: reference model produces expected state per driven cycle into a queue,
// compared after the clock edge that consumes the stimulus.
// Covers reset (initial and asynchronous mid-run), order, overflow/wrap, underflow,
// simultaneous push/pop, restore priority and clamping, plus a random phase.
module tb_ras;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int TW = 31;

    logic          CLK;
    logic          RST;
    logic          link_valid;
    logic [TW-1:0] link_target;
    logic          ret_valid;
    logic          restore_valid;
    logic [IW-1:0] restore_index;
    logic [IW:0]   restore_count;
    logic [TW-1:0] ret_target;
    logic [IW-1:0] ras_index;
    logic [IW:0]   ras_count;
    logic          ras_empty;

    ras #(
        .RAS_ENTRIES(N),
        .RAS_INDEX_WIDTH(IW),
        .RAS_TARGET_WIDTH(TW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .link_valid(link_valid),
        .link_target(link_target),
        .ret_valid(ret_valid),
        .restore_valid(restore_valid),
        .restore_index(restore_index),
        .restore_count(restore_count),
        .ret_target(ret_target),
        .ras_index(ras_index),
        .ras_count(ras_count),
        .ras_empty(ras_empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string          tag;
        logic [TW-1:0]  tgt;
        int             idx;
        int             cnt;
        logic           empty;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [TW-1:0] m_stack [N];
    int            m_idx;
    int            m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_stack[i] = '0;
        m_idx = 0;
        m_cnt = 0;
    endtask

    task automatic model_step(input logic lv, input logic [TW-1:0] lt, input logic rv,
                              input logic sv, input int si, input int sc);
        if (sv) begin
            m_idx = si;
            m_cnt = (sc > N) ? N : sc;
        end else if (lv && !rv) begin
            m_idx = (m_idx + 1) % N;
            m_stack[m_idx] = lt;
            m_cnt = (m_cnt + 1 > N) ? N : m_cnt + 1;
        end else if (rv && !lv) begin
            if (m_cnt > 0) begin
                m_idx = (m_idx + N - 1) % N;
                m_cnt = m_cnt - 1;
            end
        end else if (lv && rv) begin
            m_stack[m_idx] = lt;
            if (m_cnt < 1) m_cnt = 1;
        end
    endtask

    // Called at posedge+1: drive one cycle, predict, then compare after the edge.
    task automatic step(input string tag, input logic lv, input logic [TW-1:0] lt,
                        input logic rv, input logic sv, input int si, input int sc);
        exp_t e;
        exp_t g;
        link_valid    = lv;
        link_target   = lt;
        ret_valid     = rv;
        restore_valid = sv;
        restore_index = IW'(si);
        restore_count = (IW+1)'(sc);
        model_step(lv, lt, rv, sv, si, sc);
        e.tag   = tag;
        e.tgt   = m_stack[m_idx];
        e.idx   = m_idx;
        e.cnt   = m_cnt;
        e.empty = (m_cnt == 0);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        link_valid    = 1'b0;
        ret_valid     = 1'b0;
        restore_valid = 1'b0;
        if (exp_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            g = exp_q.pop_front();
            chk({g.tag, ".tgt"},   32'(ret_target), 32'(g.tgt));
            chk({g.tag, ".idx"},   32'(ras_index),  32'(g.idx));
            chk({g.tag, ".cnt"},   32'(ras_count),  32'(g.cnt));
            chk({g.tag, ".empty"}, 32'(ras_empty),  32'(g.empty));
        end
    endtask

    task automatic push(input string tag, input logic [TW-1:0] t);
        step(tag, 1'b1, t, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic pop(input string tag);
        step(tag, 1'b0, '0, 1'b1, 1'b0, 0, 0);
    endtask

    // Synchronous-looking reset pulse placed between edges; returns at posedge+1.
    task automatic pulse_reset();
        #2 RST = 1'b1;
        model_reset();
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int cap_idx;
    int cap_cnt;

    initial begin
        RST           = 1'b1;
        link_valid    = 1'b0;
        link_target   = '0;
        ret_valid     = 1'b0;
        restore_valid = 1'b0;
        restore_index = '0;
        restore_count = '0;
        model_reset();

        // Reset state
        #1;
        chk("rst.tgt",   32'(ret_target), 32'd0);
        chk("rst.idx",   32'(ras_index),  32'd0);
        chk("rst.cnt",   32'(ras_count),  32'd0);
        chk("rst.empty", 32'(ras_empty),  32'd1);
        #11 RST = 1'b0;
        @(posedge CLK);
        #1;

        // Asynchronous reset mid-run, checked before any clock edge
        push("pre1", 31'h0AAA);
        push("pre2", 31'h0BBB);
        push("pre3", 31'h0CCC);
        #2 RST = 1'b1;
        #1;
        chk("arst.tgt",   32'(ret_target), 32'd0);
        chk("arst.idx",   32'(ras_index),  32'd0);
        chk("arst.cnt",   32'(ras_count),  32'd0);
        chk("arst.empty", 32'(ras_empty),  32'd1);
        model_reset();
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;

        // Push/pop order, then underflow
        push("ord.p1", 31'h1000);
        push("ord.p2", 31'h2000);
        push("ord.p3", 31'h3000);
        chk("ord.top", 32'(ret_target), 32'h3000);
        pop("ord.r1");
        chk("ord.r1v", 32'(ret_target), 32'h2000);
        pop("ord.r2");
        chk("ord.r2v", 32'(ret_target), 32'h1000);
        pop("ord.r3");
        chk("ord.r3v", 32'(ret_target), 32'h0);
        pop("uflow");
        chk("uflow.idx", 32'(ras_index), 32'd0);

        // Simultaneous push+pop at empty
        step("pp0", 1'b1, 31'h0055, 1'b1, 1'b0, 0, 0);
        chk("pp0.cnt", 32'(ras_count), 32'd1);

        // Overflow and wrap from a clean stack
        pulse_reset();
        for (int i = 1; i <= 9; i++) push($sformatf("ovf.p%0d", i), TW'(i));
        chk("ovf.idx", 32'(ras_index),  32'd1);
        chk("ovf.cnt", 32'(ras_count),  32'd8);
        chk("ovf.top", 32'(ret_target), 32'h9);
        for (int i = 1; i <= 8; i++) pop($sformatf("ovf.r%0d", i));
        chk("ovf.lost", 32'(ret_target), 32'h9);

        // Simultaneous push+pop at count 2, top 0xA
        pulse_reset();
        push("pp2.a", 31'h000C);
        push("pp2.b", 31'h000A);
        step("pp2", 1'b1, 31'h000B, 1'b1, 1'b0, 0, 0);
        chk("pp2.top", 32'(ret_target), 32'hB);
        pop("pp2.r");
        chk("pp2.old", 32'(ret_target), 32'hC);

        // Restore priority and clamping
        pulse_reset();
        push("rs.p1", 31'h0010);
        push("rs.p2", 31'h0020);
        cap_idx = m_idx;
        cap_cnt = m_cnt;
        push("rs.p3", 31'h0030);
        push("rs.p4", 31'h0040);
        step("rs.go", 1'b1, 31'h0DEAD, 1'b0, 1'b1, cap_idx, cap_cnt);
        chk("rs.top", 32'(ret_target), 32'h20);
        step("rs.pop", 1'b0, '0, 1'b1, 1'b1, 4, 3);
        chk("rs.top2", 32'(ret_target), 32'h40);
        step("rs.clamp", 1'b0, '0, 1'b0, 1'b1, 1, 9);
        chk("rs.clampc", 32'(ras_count), 32'd8);
        step("rs.clamp15", 1'b1, 31'h7, 1'b1, 1'b1, 5, 15);

        // Random mix
        for (int n = 0; n < 400; n++) begin
            logic lv;
            logic rv;
            logic sv;
            lv = ($urandom_range(0, 99) < 45);
            rv = ($urandom_range(0, 99) < 45);
            sv = ($urandom_range(0, 99) < 6);
            step("rnd", lv, TW'($urandom), rv, sv,
                 int'($urandom_range(0, N-1)), int'($urandom_range(0, 15)));
        end

        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
